// File: rtl/data_mem_hs.sv
// data_mem_hs: handshaked, little-endian byte-addressable data memory with registered responses.
// Define DATA_MEM_HS_MISALIGN_EN to service misaligned in-range accesses as two word beats.
module data_mem_hs #(
  parameter int DEPTH_WORDS = 32,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  MemWrite,
  input  logic [2:0]  MemRead,
  input  logic [31:0] address,
  input  logic [31:0] write_data,
  output logic        rsp_valid,
  output logic [31:0] MemRead_data,
  output logic        err
);

  localparam logic [32:0] BYTE_CAP = 33'(DEPTH_WORDS) * 33'd4;

  typedef enum logic [1:0] {CLS_ERR, CLS_NOOP, CLS_ONE, CLS_SPLIT} cls_e;

  // Size codes: 01 word, 10 half, 11 byte.
  function automatic logic [31:0] load_fmt(input logic [31:0] raw, input logic [1:0] size,
                                           input logic sext);
    logic [31:0] res;
    case (size)
      2'b10:   res = {{16{sext & raw[15]}}, raw[15:0]};
      2'b11:   res = {{24{sext & raw[7]}}, raw[7:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  logic [31:0]   r_mem [DEPTH_WORDS];
  logic          r_rsp_valid;
  logic          r_err;
  logic [31:0]   r_data;

  logic          w_accept;
  logic          w_is_wr;
  logic          w_is_rd;
  logic [1:0]    w_size;
  logic [1:0]    w_off;
  logic [2:0]    w_nbytes;
  logic [3:0]    w_mask;
  logic [3:0]    w_be_lo;
  logic [32:0]   w_last;
  logic          w_oob;
  logic          w_misal;
  logic [AW-1:0] w_word;
  logic [31:0]   w_wdata_lo;
  logic [31:0]   w_rd_raw;
  cls_e          w_cls;

  // NOTE: every signal driven here gets a default before any branch, so no latch is inferred.
  always_comb begin
    w_is_wr  = |MemWrite;
    w_is_rd  = |MemRead[1:0];
    w_size   = w_is_wr ? MemWrite : MemRead[1:0];
    w_off    = address[1:0];
    w_word   = address[AW+1:2];
    w_mask   = 4'h0;
    w_nbytes = 3'd0;
    case (w_size)
      2'b01:   begin w_mask = 4'hF; w_nbytes = 3'd4; end
      2'b10:   begin w_mask = 4'h3; w_nbytes = 3'd2; end
      2'b11:   begin w_mask = 4'h1; w_nbytes = 3'd1; end
      default: ;
    endcase
    w_last     = {1'b0, address} + {30'b0, w_nbytes} - 33'd1;
    w_oob      = (w_last >= BYTE_CAP);
    w_misal    = ((w_size == 2'b01) && (w_off != 2'b00)) || ((w_size == 2'b10) && (w_off == 2'b11));
    w_be_lo    = w_mask << w_off;
    w_wdata_lo = write_data << {w_off, 3'b000};
    w_rd_raw   = r_mem[w_word] >> {w_off, 3'b000};

    w_cls = CLS_ONE;
    if (w_is_wr && w_is_rd)        w_cls = CLS_ERR;
    else if (!w_is_wr && !w_is_rd) w_cls = CLS_NOOP;
    else if (w_oob)                w_cls = CLS_ERR;
    else if (w_misal) begin
`ifdef DATA_MEM_HS_MISALIGN_EN
      // An in-range misaligned access never has its upper word past the array end.
      w_cls = CLS_SPLIT;
`else
      w_cls = CLS_ERR;
`endif
    end
  end

  assign w_accept = req_valid && req_ready && !reset;

`ifdef DATA_MEM_HS_MISALIGN_EN
  typedef enum logic {S_IDLE, S_SPLIT} state_e;

  state_e        r_state;
  state_e        w_state_nxt;
  logic          r_sp_wr;
  logic          r_sp_sext;
  logic [1:0]    r_sp_off;
  logic [1:0]    r_sp_size;
  logic [AW-1:0] r_sp_word_hi;
  logic [3:0]    r_sp_be_hi;
  logic [31:0]   r_sp_wdata_hi;
  logic [31:0]   r_sp_lo_raw;
  logic [3:0]    w_be_hi;
  logic [31:0]   w_wdata_hi;
  logic [31:0]   w_sp_raw;

  assign w_be_hi    = w_mask >> (3'd4 - {1'b0, w_off});
  assign w_wdata_hi = write_data >> {3'd4 - {1'b0, w_off}, 3'b000};
  assign w_sp_raw   = r_sp_lo_raw | (r_mem[r_sp_word_hi] << {3'd4 - {1'b0, r_sp_off}, 3'b000});
  assign req_ready  = (r_state == S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (w_accept && (w_cls == CLS_SPLIT)) w_state_nxt = S_SPLIT;
      S_SPLIT: w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Everything the second beat needs, captured at accept.
  always_ff @(posedge clk) begin
    if (w_accept && (w_cls == CLS_SPLIT)) begin
      r_sp_wr       <= w_is_wr;
      r_sp_sext     <= MemRead[2];
      r_sp_off      <= w_off;
      r_sp_size     <= w_size;
      r_sp_word_hi  <= w_word + AW'(1);
      r_sp_be_hi    <= w_be_hi;
      r_sp_wdata_hi <= w_wdata_hi;
      r_sp_lo_raw   <= w_rd_raw;
    end
  end
`else
  assign req_ready = 1'b1;
`endif

  // NOTE: the array is deliberately left out of reset; only control and response state is reset.
  always_ff @(posedge clk) begin
    if (w_accept && w_is_wr && ((w_cls == CLS_ONE) || (w_cls == CLS_SPLIT))) begin
      for (int k = 0; k < 4; k++)
        if (w_be_lo[k]) r_mem[w_word][8*k +: 8] <= w_wdata_lo[8*k +: 8];
    end
`ifdef DATA_MEM_HS_MISALIGN_EN
    if (!reset && (r_state == S_SPLIT) && r_sp_wr) begin
      for (int k = 0; k < 4; k++)
        if (r_sp_be_hi[k]) r_mem[r_sp_word_hi][8*k +: 8] <= r_sp_wdata_hi[8*k +: 8];
    end
`endif
  end

  // NOTE: non-blocking assignments keep every register update tied to the same clock edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_rsp_valid <= 1'b0;
      r_err       <= 1'b0;
      r_data      <= '0;
    end else begin
      r_rsp_valid <= 1'b0;
      if (w_accept) begin
        case (w_cls)
          CLS_ERR: begin
            r_rsp_valid <= 1'b1;
            r_err       <= 1'b1;
            r_data      <= '0;
          end
          CLS_NOOP: begin
            r_rsp_valid <= 1'b1;
            r_err       <= 1'b0;
            r_data      <= '0;
          end
          CLS_ONE: begin
            r_rsp_valid <= 1'b1;
            r_err       <= 1'b0;
            r_data      <= w_is_wr ? '0 : load_fmt(w_rd_raw, w_size, MemRead[2]);
          end
          default: ;
        endcase
      end
`ifdef DATA_MEM_HS_MISALIGN_EN
      else if (r_state == S_SPLIT) begin
        r_rsp_valid <= 1'b1;
        r_err       <= 1'b0;
        r_data      <= r_sp_wr ? '0 : load_fmt(w_sp_raw, r_sp_size, r_sp_sext);
      end
`endif
    end
  end

  assign rsp_valid    = r_rsp_valid;
  assign MemRead_data = r_data;
  assign err          = r_err;

endmodule

// File: tb/tb_data_mem_hs.sv
// tb_data_mem_hs: randomized bench for data_mem_hs against a byte-array reference model.
// Follows DATA_MEM_HS_MISALIGN_EN when it is defined for the build.
module tb_data_mem_hs;
  localparam int DEPTH = 32;
  localparam int BYTES = DEPTH * 4;
`ifdef DATA_MEM_HS_MISALIGN_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  MemWrite = '0;
  logic [2:0]  MemRead = '0;
  logic [31:0] address = '0;
  logic [31:0] write_data = '0;
  logic        rsp_valid;
  logic [31:0] MemRead_data;
  logic        err;

  always #5 clk = ~clk;

  data_mem_hs #(.DEPTH_WORDS(DEPTH)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .MemWrite(MemWrite), .MemRead(MemRead), .address(address), .write_data(write_data),
    .rsp_valid(rsp_valid), .MemRead_data(MemRead_data), .err(err)
  );

  typedef struct {
    int          due;
    logic        err;
    logic [31:0] data;
  } rsp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int          cyc     = 0;
  rsp_t        exp_q[$];
  logic [7:0]  ref_mem [BYTES];
  int          pend_addr[$];
  logic [7:0]  pend_byte[$];
  bit          split_busy = 1'b0;
  logic [31:0] last_data = '0;
  logic        last_err  = 1'b0;
  logic [31:0] seen_data = '0;
  logic        seen_err  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Reference: classify the request from the rules, then act on a byte array.
  task automatic model_accept(input logic [1:0] wr, input logic [2:0] rd, input logic [31:0] addr,
                              input logic [31:0] wd, output bit is_split);
    rsp_t        r;
    logic [1:0]  sz;
    int          n;
    longint      last;
    bit          mis;
    logic [31:0] v;
    int          a;
    is_split = 1'b0;
    r.due  = cyc;
    r.err  = 1'b0;
    r.data = '0;
    sz   = (wr != 2'b00) ? wr : rd[1:0];
    n    = (sz == 2'b01) ? 4 : (sz == 2'b10) ? 2 : (sz == 2'b11) ? 1 : 0;
    last = longint'(addr) + n - 1;
    mis  = ((sz == 2'b01) && (addr % 4 != 0)) || ((sz == 2'b10) && (addr % 4 == 3));
    if ((wr != 2'b00) && (rd[1:0] != 2'b00)) r.err = 1'b1;
    else if (n == 0) r.err = 1'b0;
    else if (last >= BYTES) r.err = 1'b1;
    else if (mis && !MIS_EN) r.err = 1'b1;
    else begin
      is_split = mis;
      if (mis) r.due = cyc + 1;
      if (wr != 2'b00) begin
        for (int i = 0; i < n; i++) begin
          a = int'(addr) + i;
          if (mis && (a / 4 != int'(addr) / 4)) begin
            pend_addr.push_back(a);
            pend_byte.push_back(wd[8*i +: 8]);
          end else begin
            ref_mem[a] = wd[8*i +: 8];
          end
        end
      end else begin
        v = '0;
        for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[int'(addr) + i];
        if (rd[2] && (n < 4) && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
        r.data = v;
      end
    end
    exp_q.push_back(r);
  endtask

  // One clock cycle: drive at negedge, sample #1 after posedge.
  task automatic step(input bit v, input logic [1:0] wr, input logic [2:0] rd,
                      input logic [31:0] addr, input logic [31:0] wd, input bit rst);
    bit   exp_ready;
    bit   acc;
    bit   sp;
    rsp_t r;
    @(negedge clk);
    req_valid  = v;
    MemWrite   = wr;
    MemRead    = rd;
    address    = addr;
    write_data = wd;
    reset      = rst;
    exp_ready  = !split_busy;
    #1;
    if (cyc > 0) check("req_ready", 32'(req_ready), 32'(exp_ready));
    acc = v && exp_ready && !rst;
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      exp_q.delete();
      pend_addr.delete();
      pend_byte.delete();
      split_busy = 1'b0;
      last_data  = '0;
      last_err   = 1'b0;
    end else begin
      if (split_busy) begin
        foreach (pend_addr[i]) ref_mem[pend_addr[i]] = pend_byte[i];
        pend_addr.delete();
        pend_byte.delete();
        split_busy = 1'b0;
      end
      if (acc) begin
        model_accept(wr, rd, addr, wd, sp);
        split_busy = sp;
      end
    end
    if ((exp_q.size() > 0) && (exp_q[0].due == cyc)) begin
      r = exp_q.pop_front();
      check("rsp_valid", 32'(rsp_valid), 32'd1);
      check("rsp_err", 32'(err), 32'(r.err));
      check("rsp_data", MemRead_data, r.data);
      last_data = r.data;
      last_err  = r.err;
      seen_data = MemRead_data;
      seen_err  = err;
    end else begin
      check("rsp_idle", 32'(rsp_valid), 32'd0);
      check("hold_data", MemRead_data, last_data);
      check("hold_err", 32'(err), 32'(last_err));
    end
  endtask

  task automatic idle();
    step(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b0);
  endtask

  initial begin
    step(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b1);
    step(1'b0, 2'b00, 3'b000, 32'h0, 32'h0, 1'b1);
    idle();
    for (int w = 0; w < DEPTH; w++) step(1'b1, 2'b01, 3'b000, 32'(4 * w), $urandom, 1'b0);
    idle();

    step(1'b1, 2'b01, 3'b000, 32'h10, 32'hDEAD_BEEF, 1'b0);
    step(1'b1, 2'b00, 3'b111, 32'h13, 32'h0, 1'b0);
    check("tp_lb_sext", seen_data, 32'hFFFF_FFDE);
    step(1'b1, 2'b00, 3'b010, 32'h10, 32'h0, 1'b0);
    check("tp_lh_zext", seen_data, 32'h0000_BEEF);

    step(1'b1, 2'b11, 3'b000, 32'h21, 32'h0000_005A, 1'b0);
    step(1'b1, 2'b00, 3'b001, 32'h20, 32'h0, 1'b0);
    check("tp_b2b_byte1", 32'(seen_data[15:8]), 32'h5A);

    step(1'b1, 2'b00, 3'b001, 32'h7C, 32'h0, 1'b0);
    check("tp_top_ok", 32'(seen_err), 32'd0);
    step(1'b1, 2'b00, 3'b001, 32'h80, 32'h0, 1'b0);
    check("tp_oob_load", 32'(seen_err), 32'd1);
    step(1'b1, 2'b01, 3'b000, 32'h80, 32'h1234_5678, 1'b0);
    check("tp_oob_store", 32'(seen_err), 32'd1);
    step(1'b1, 2'b00, 3'b001, 32'h7C, 32'h0, 1'b0);

    step(1'b1, 2'b01, 3'b000, 32'h0E, 32'h1122_3344, 1'b0);
`ifndef DATA_MEM_HS_MISALIGN_EN
    check("tp_mis_err", 32'(seen_err), 32'd1);
`endif
    idle();
`ifdef DATA_MEM_HS_MISALIGN_EN
    check("tp_mis_ok", 32'(seen_err), 32'd0);
`endif
    step(1'b1, 2'b00, 3'b001, 32'h0C, 32'h0, 1'b0);
`ifdef DATA_MEM_HS_MISALIGN_EN
    check("tp_mis_lo", 32'(seen_data[31:16]), 32'h3344);
`endif
    step(1'b1, 2'b00, 3'b001, 32'h10, 32'h0, 1'b0);
`ifdef DATA_MEM_HS_MISALIGN_EN
    check("tp_mis_hi", 32'(seen_data[15:0]), 32'h1122);
`endif

    step(1'b1, 2'b01, 3'b001, 32'h30, 32'hFFFF_FFFF, 1'b0);
    check("tp_conflict", 32'(seen_err), 32'd1);
    step(1'b1, 2'b00, 3'b000, 32'h30, 32'hFFFF_FFFF, 1'b0);
    check("tp_noop_err", 32'(seen_err), 32'd0);
    check("tp_noop_data", seen_data, 32'h0);
    step(1'b1, 2'b00, 3'b001, 32'h30, 32'h0, 1'b0);

    step(1'b1, 2'b01, 3'b000, 32'h26, 32'hCAFE_F00D, 1'b0);
    step(1'b1, 2'b00, 3'b001, 32'h24, 32'h0, 1'b1);
    idle();
    step(1'b1, 2'b00, 3'b001, 32'h24, 32'h0, 1'b0);
    step(1'b1, 2'b00, 3'b001, 32'h28, 32'h0, 1'b0);

    for (int it = 0; it < 3000; it++) begin
      int          op;
      int          p;
      logic [1:0]  sz;
      logic [1:0]  wr;
      logic [2:0]  rd;
      logic [31:0] a;
      op = $urandom_range(0, 19);
      p  = $urandom_range(0, 19);
      sz = 2'($urandom_range(1, 3));
      wr = 2'b00;
      rd = 3'b000;
      if (op < 9)       rd = {1'($urandom_range(0, 1)), sz};
      else if (op < 18) wr = sz;
      else if (op == 18) begin
        wr = sz;
        rd = {1'b0, 2'($urandom_range(1, 3))};
      end
      if (p < 16)      a = 32'($urandom_range(0, BYTES - 1));
      else if (p < 19) a = 32'($urandom_range(BYTES - 8, BYTES + 7));
      else             a = $urandom;
      step(($urandom_range(0, 7) != 0), wr, rd, a, $urandom, ($urandom_range(0, 299) == 0));
    end

    for (int i = 0; i < 4; i++) idle();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/data_mem_hs.md
# data_mem_hs

Parametrised, handshaked successor to the single-cycle data memory: a little-endian byte-addressable store of DEPTH_WORDS 32-bit words with byte/half/word loads and stores, sign/zero extension and a registered read path. It sits between the pipelined CPU's MEM stage and its data array. It adds range checking, an error response and, when configured, two-beat handling of accesses that straddle a word boundary.

## Interface
- DEPTH_WORDS, 32: number of 32-bit words; byte capacity is DEPTH_WORDS*4.
- AW, $clog2(DEPTH_WORDS): word-index width.
- clk  in  1  clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept; a request transfers when req_valid && req_ready.
- MemWrite  in  2  store size: 00 none, 01 word, 10 half, 11 byte.
- MemRead  in  3  [1:0] load size with the same encoding as MemWrite; [2] sign-extend half or byte loads.
- address  in  32  byte address.
- write_data  in  32  store data; low bytes are used for half and byte stores.
- rsp_valid  out  1  one-cycle pulse; response for the oldest accepted request.
- MemRead_data  out  32  load result; valid with rsp_valid; 0 for stores, no-ops and errors.
- err  out  1  valid with rsp_valid; request was illegal and had no effect.

## Operation
- Storage is an array of DEPTH_WORDS x 32 with per-byte enables. Byte k of a word is bits [8k+7:8k].
- Contents are not cleared by reset.
- **Request classes**, decoded at accept time:
  - Both MemWrite != 0 and MemRead[1:0] != 0: err=1, no access.
  - Both fields zero: no-op response, err=0, data 0.
  - Out of range, i.e. address + size - 1 >= DEPTH_WORDS*4 (computed in 33 bits): err=1, no write.
  - Misaligned: a word access with address[1:0] != 0, or a half access with address[1:0] == 3.
  - Aligned, in range: one-beat access.
- **Loads:** bytes are assembled little-endian.
  - Half: bit 15 is replicated into [31:16] if MemRead[2], otherwise zeros.
  - Byte: bit 7 is replicated into [31:8] if MemRead[2], otherwise zeros.
  - Word: MemRead[2] is ignored.
- **Stores:** only the addressed bytes are written.
- **FSM, IDLE state:** req_ready=1. An accepted one-beat request is performed in the accept cycle.
  - Write: committed at that edge.
  - Read: data is registered at that edge.
  - The response is registered, and the FSM stays in IDLE.
  - An accepted misaligned request, with the feature enabled, goes to SPLIT.
- **FSM, SPLIT state:** req_ready=0. Performs the second-word beat, registers the response, and returns to IDLE.
- **Ordering:** a store followed by a load to the same bytes in the next cycle returns the new data. No bypass is needed, because the write commits before the load reads.

## Timing
- Reset values: req_ready=1, rsp_valid=0, MemRead_data=0, err=0, FSM=IDLE.
- One-beat requests:
  - Accept in cycle T; rsp_valid is high in T+1.
  - Requests are fully pipelined: one request per cycle, one response per cycle.
- Split requests:
  - Accept in T; first-word beat in T; second-word beat in T+1; rsp_valid in T+2.
  - req_ready is 0 during T+1.
- Error and no-op requests: response in T+1, with no array side effects.
- There is no response backpressure: the consumer must take rsp_valid when it pulses.
- rsp_valid is 0 in any cycle without a completing request. MemRead_data and err hold their last values.
- Reset asserted during SPLIT:
  - The second beat is abandoned and no response is issued.
  - A split store keeps its first-beat bytes, leaving a partial write. This is accepted behaviour.
- Requests presented while req_ready=0 are ignored; the requester must hold them.

## Configuration
- DATA_MEM_HS_MISALIGN_EN defined:
  - Misaligned in-range accesses are split across word w = address[AW+1:2] and word w+1, taking 2 cycles.
  - If w+1 >= DEPTH_WORDS, the request is range-illegal: err=1, single cycle.
- DATA_MEM_HS_MISALIGN_EN undefined:
  - Misaligned requests get err=1 in T+1 with no write.
  - SPLIT is not compiled, and req_ready is constant 1 outside reset.

## Test plan
- Store word 0xDEADBEEF at 0x10, then load byte at 0x13 with MemRead=3'b111 -> next cycle data 0xFFFFFFDE, err=0. Load half at 0x10 with MemRead=3'b010 -> 0x0000BEEF.
- Back-to-back: store byte 0x5A at 0x21 in T, load word 0x20 in T+1 -> rsp at T+2 has byte1=0x5A and other bytes unchanged. rsp_valid is high in T+1 and T+2.
- Range check, DEPTH_WORDS=32:
  - Word load at 0x7C -> err=0.
  - Word load at 0x80 -> err=1, data 0.
  - Word store at 0x80 -> err=1, array unchanged.
- Misaligned word store 0x11223344 at 0x0E:
  - With the macro: req_ready=0 for one cycle, rsp at T+2, err=0. Word 0x0C then reads 0x3344xxxx and word 0x10 reads xxxx1122.
  - Without the macro: err at T+1, memory unchanged.
- MemWrite=01 with MemRead=001 together -> err=1, no write. Both zero -> rsp_valid=1, err=0, data 0.
- Reset asserted in the SPLIT cycle of a misaligned store -> no rsp_valid. Outputs return to reset values and req_ready=1 on the next cycle. First-word bytes are written and second-word bytes are not.
